// File: rtl/shift_in_collector_pkg.sv
// ----------------------------------------------------------------------------
// shift_in_collector_pkg
//   Shared definitions for the serial-to-parallel collector:
//     WIDTH_DEFAULT    default word length (matches the paired shift_out)
//     collect_state_t  IDLE (no bits gathered) / COLLECT (partial word)
//     buf_state_t      EMPTY / FULL state of the single-word output buffer
// ----------------------------------------------------------------------------
package shift_in_collector_pkg;

   localparam int WIDTH_DEFAULT = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } collect_state_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

endpackage : shift_in_collector_pkg

// File: rtl/shift_in_collector_bit_counter.sv
// ----------------------------------------------------------------------------
// bit_counter
//   Modulo-MODULUS counter of sampled bits.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset (count -> 0)
//     en     count one bit this edge
//     clr    synchronous clear; when combined with en the counted bit is the
//            first of a fresh sequence
//     count  current count, 0..MODULUS-1
//     wrap   combinational: this edge's counted bit completes a word
// ----------------------------------------------------------------------------
module bit_counter #(
   parameter int MODULUS = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             clr,
   output logic [$clog2(MODULUS+1)-1:0]     count,
   output logic                             wrap
);

   localparam int CW = $clog2(MODULUS + 1);
   localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [CW-1:0] start;

   // A clear restarts the count before the same-edge bit is counted, so
   // clr & en leaves count=1 (or wraps immediately when MODULUS=1).
   always_comb begin
      start      = clr ? '0 : count_reg;
      wrap       = en && (start == LAST);
      count_next = start;
      if (en) begin
         count_next = wrap ? '0 : start + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule : bit_counter

// File: rtl/shift_in_collector.sv
// ----------------------------------------------------------------------------
// shift_in_collector
//   Assembles LSB-first serial bits into WIDTH-bit words with a one-word
//   output buffer and a sticky overrun flag.
//   Ports:
//     clk         clock, rising edge
//     rst_n       asynchronous active-low reset
//     shift       bit-valid strobe; serial_in sampled when 1
//     serial_in   serial data, LSB first
//     sync        frame realign, discards any partial word
//     word_ready  consumer accepts the held word
//     clr_ovr     clears the sticky overrun flag
//     word        assembled parallel word
//     word_valid  word holds an unconsumed value
//     busy        partial word in progress
//     overrun     sticky, a completed word was dropped
// ----------------------------------------------------------------------------
module shift_in_collector
   import shift_in_collector_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift,
   input  logic             serial_in,
   input  logic             sync,
   input  logic             word_ready,
   input  logic             clr_ovr,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    count;
   logic             wrap;
   logic [WIDTH-1:0] sr_reg;
   logic [WIDTH-1:0] sr_next;
   logic [WIDTH-1:0] word_reg;
   logic             overrun_reg;
   logic             consume;
   collect_state_t   collect_state;
   buf_state_t       buf_state_reg;

   bit_counter #(
      .MODULUS (WIDTH)
   ) u_bit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (shift),
      .clr   (sync),
      .count (count),
      .wrap  (wrap)
   );

   // New bits enter at the MSB and move down, so after WIDTH shifts the
   // first sampled bit sits in bit 0. For WIDTH=1 this degenerates to
   // sr_next = serial_in.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_msb
         assign sr_next[gi] = serial_in;
      end else begin : g_low
         assign sr_next[gi] = sr_reg[gi+1];
      end
   end

   // The collect state is a decode of the bit count.
   assign collect_state = (count != '0) ? COLLECT : IDLE;
   assign busy          = (collect_state == COLLECT);

   assign consume = (buf_state_reg == FULL) && word_ready;

   // Shift register, output buffer FSM, held word and overrun flag.
   // A completing word is accepted when the buffer is empty or is being
   // drained on the same edge; otherwise it is dropped and overrun set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_reg        <= '0;
         word_reg      <= '0;
         buf_state_reg <= EMPTY;
         overrun_reg   <= 1'b0;
      end else begin
         if (shift) begin
            sr_reg <= sr_next;
         end

         case (buf_state_reg)
            EMPTY: begin
               if (wrap) begin
                  word_reg      <= sr_next;
                  buf_state_reg <= FULL;
               end
            end
            FULL: begin
               if (wrap && word_ready) begin
                  word_reg <= sr_next;
               end else if (word_ready) begin
                  buf_state_reg <= EMPTY;
               end
            end
            default: buf_state_reg <= EMPTY;
         endcase

         // Set has priority over clear.
         if (wrap && (buf_state_reg == FULL) && !word_ready) begin
            overrun_reg <= 1'b1;
         end else if (clr_ovr) begin
            overrun_reg <= 1'b0;
         end
      end
   end

   assign word       = word_reg;
   assign word_valid = (buf_state_reg == FULL);
   assign overrun    = overrun_reg;

endmodule : shift_in_collector
